// File: rtl/pol_ofm_responder_pkg.sv
// pol_ofm_responder_pkg: shared defaults and width helpers for the pooling ofm responder
package pol_ofm_responder_pkg;
  localparam int IDX_WIDTH_DEF = 10;
  localparam int ACT_WIDTH_DEF = 8;
  localparam int POOL_COMP_CORE_DEF = 64;
  localparam int POOL_CORE_DEF = 6;
  localparam int RD_LAT_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  function automatic int data_w(input int act_w, input int comp);
    return act_w * comp;
  endfunction
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pol_ofm_responder_fifo.sv
// pol_rsp_fifo: per-core return FIFO with synchronous clear; head is shown while non-empty
module pol_rsp_fifo import pol_ofm_responder_pkg::*; #(
  parameter int DW = 512,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = id_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= push_i ? nxt(wp_q) : wp_q;
      rp_q <= pop_i ? nxt(rp_q) : rp_q;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wp_q] <= din_i;
  end
  // credits bound occupancy plus in-flight reads, so a full FIFO never sees a write
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o && !clr_i));
endmodule

// File: rtl/pol_ofm_responder.sv
// pol_ofm_responder: round-robin per-core address arbiter onto one SRAM read port with credited return FIFOs
module pol_ofm_responder import pol_ofm_responder_pkg::*; #(
  parameter int IDX_WIDTH = IDX_WIDTH_DEF,
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int POOL_COMP_CORE = POOL_COMP_CORE_DEF,
  parameter int POOL_CORE = POOL_CORE_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int DATA_WIDTH = data_w(ACT_WIDTH, POOL_COMP_CORE)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CCUGLB_Rst,
  input  logic [POOL_CORE-1:0]            POLGLB_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]  POLGLB_Addr,
  output logic [POOL_CORE-1:0]            GLBPOL_AddrRdy,
  output logic                            GLBSRAM_RdVld,
  output logic [IDX_WIDTH-1:0]            GLBSRAM_RdAddr,
  input  logic [DATA_WIDTH-1:0]           SRAMGLB_RdDat,
  output logic [DATA_WIDTH*POOL_CORE-1:0] GLBPOL_Ofm,
  output logic [POOL_CORE-1:0]            GLBPOL_OfmVld,
  input  logic [POOL_CORE-1:0]            POLGLB_OfmRdy
);
  localparam int IW = id_w(POOL_CORE);
  localparam int CW = cnt_w(FIFO_DEPTH);
  logic [CW-1:0] cnt_q [POOL_CORE];
  logic [CW-1:0] cnt_d [POOL_CORE];
  logic [IW-1:0] ptr_q, ptr_d, gid, rdid_q;
  logic [POOL_CORE-1:0] elig, grant, pop, push, empty;
  logic found, rdvld_q;
  logic [IDX_WIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [RD_LAT-1:0] pv_q;
  logic [IW-1:0] pid_q [RD_LAT];
  logic [DATA_WIDTH-1:0] head [POOL_CORE];
  assign pop = ~empty & POLGLB_OfmRdy;
  assign GLBPOL_OfmVld = ~empty;
  assign GLBPOL_AddrRdy = grant;
  assign GLBSRAM_RdVld = rdvld_q;
  assign GLBSRAM_RdAddr = rdaddr_q;
  // a same-cycle pop returns its credit immediately so one core can stream at full rate
  always_comb begin
    for (int i = 0; i < POOL_CORE; i++)
      elig[i] = rst_n && !CCUGLB_Rst && POLGLB_AddrVld[i] && ((cnt_q[i] < CW'(FIFO_DEPTH)) || pop[i]);
  end
  always_comb begin
    grant = '0;
    gid = '0;
    found = 1'b0;
    for (int k = 0; k < POOL_CORE; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % POOL_CORE]) begin
        found = 1'b1;
        gid = IW'((int'(ptr_q) + k) % POOL_CORE);
      end
    end
    if (found) grant[gid] = 1'b1;
    ptr_d = !found ? ptr_q : (gid == IW'(POOL_CORE - 1)) ? '0 : gid + 1'b1;
    rdaddr_d = found ? POLGLB_Addr[IDX_WIDTH*gid +: IDX_WIDTH] : rdaddr_q;
    for (int i = 0; i < POOL_CORE; i++) cnt_d[i] = cnt_q[i] + CW'(grant[i]) - CW'(pop[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      rdvld_q <= 1'b0;
      rdaddr_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < POOL_CORE; i++) cnt_q[i] <= '0;
    end else if (CCUGLB_Rst) begin
      ptr_q <= '0;
      rdvld_q <= 1'b0;
      rdaddr_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < POOL_CORE; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      rdvld_q <= found;
      rdaddr_q <= rdaddr_d;
      pv_q[0] <= rdvld_q;
      for (int k = 1; k < RD_LAT; k++) pv_q[k] <= pv_q[k-1];
      for (int i = 0; i < POOL_CORE; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  always_ff @(posedge clk) begin
    rdid_q <= gid;
    pid_q[0] <= rdid_q;
    for (int k = 1; k < RD_LAT; k++) pid_q[k] <= pid_q[k-1];
  end
  for (genvar i = 0; i < POOL_CORE; i++) begin : g_core
    assign push[i] = pv_q[RD_LAT-1] && (pid_q[RD_LAT-1] == IW'(i));
    assign GLBPOL_Ofm[DATA_WIDTH*i +: DATA_WIDTH] = empty[i] ? '0 : head[i];
    pol_rsp_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .clr_i(CCUGLB_Rst),
      .push_i(push[i]),
      .pop_i(pop[i]),
      .din_i(SRAMGLB_RdDat),
      .dout_o(head[i]),
      .full_o(),
      .empty_o(empty[i])
    );
  end
endmodule

// File: tb/tb_pol_ofm_responder.sv
// tb_pol_ofm_responder: directed checks of arbitration, latency, credits, flush and async reset
module tb_pol_ofm_responder;
  localparam int N = 6;
  localparam int AW = 10;
  localparam int DW = 512;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0] avld = '0;
  logic [N-1:0] ordy = '0;
  logic [N-1:0] ardy, ovld;
  logic [AW*N-1:0] addr = '0;
  logic rdvld;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddat;
  logic [DW*N-1:0] ofm;
  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_a [N][64];
  int wp [N] = '{default: 0};
  int rp [N] = '{default: 0};
  int rcv [N] = '{default: 0};
  logic [1:0] sv = '0;
  logic [AW-1:0] sa [2];

  always #5 clk = ~clk;

  pol_ofm_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .CCUGLB_Rst(flush),
    .POLGLB_AddrVld(avld),
    .POLGLB_Addr(addr),
    .GLBPOL_AddrRdy(ardy),
    .GLBSRAM_RdVld(rdvld),
    .GLBSRAM_RdAddr(rdaddr),
    .SRAMGLB_RdDat(rddat),
    .GLBPOL_Ofm(ofm),
    .GLBPOL_OfmVld(ovld),
    .POLGLB_OfmRdy(ordy)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {16{22'h2A5A5A ^ {12'h0, a}, a}};
  endfunction

  // two-cycle SRAM; junk is driven whenever no read is due
  always @(posedge clk) begin
    sv <= {sv[0], rdvld};
    sa[1] <= sa[0];
    sa[0] <= rdaddr;
  end
  assign rddat = sv[1] ? word(sa[1]) : {16{32'hBAD0BAD0}};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += wp[i] - rp[i];
    return s;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ovld[i] && ordy[i]) begin
        chk($sformatf("pend%0d", i), DW'(wp[i] != rp[i]), DW'(1));
        if (wp[i] != rp[i]) begin
          chk($sformatf("ofm%0d", i), ofm[DW*i +: DW], word(exp_a[i][rp[i] % 64]));
          rp[i]++;
        end
        rcv[i]++;
      end
      if (ardy[i]) begin
        exp_a[i][wp[i] % 64] = addr[AW*i +: AW];
        wp[i]++;
      end
      if (flush || !rst_n) rp[i] = wp[i];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[AW*i +: AW] = a;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (pending() > 0 && t < 50) begin
      step;
      t++;
    end
    chk(tag, DW'(pending()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    logic [AW-1:0] a [N];
    int n, hi, ov, t, r0;
    int rb [N];
    avld = '1;
    ordy = '1;
    smp;
    chk("rst_ardy", DW'(ardy), '0);
    chk("rst_rdvld", DW'(rdvld), '0);
    chk("rst_rdaddr", DW'(rdaddr), '0);
    chk("rst_ovld", DW'(ovld), '0);
    chk("rst_ofm", DW'(|ofm), '0);
    step;
    avld = '0;
    rst_n = 1'b1;
    step;
    // single request latency
    set_addr(0, 10'h005);
    avld = 6'b000001;
    smp;
    chk("t1_ardy", DW'(ardy), DW'(6'b000001));
    step;
    avld = '0;
    smp;
    chk("t1_rdvld", DW'(rdvld), DW'(1));
    chk("t1_rdaddr", DW'(rdaddr), DW'(10'h005));
    chk("t1_ovld_t1", DW'(ovld), '0);
    step;
    step;
    smp;
    chk("t1_ovld_t3", DW'(ovld), '0);
    step;
    smp;
    chk("t1_ovld_t4", DW'(ovld), DW'(6'b000001));
    chk("t1_ofm", ofm[0 +: DW], word(10'h005));
    step;
    smp;
    chk("t1_drain", DW'(ovld), '0);
    step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    // all cores, round robin from core 0
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(10'h100 + 16 * i);
      set_addr(i, a[i]);
      rb[i] = rcv[i];
    end
    avld = '1;
    for (int k = 0; k < 18; k++) begin
      smp;
      chk($sformatf("t2_grant%0d", k), DW'(ardy), DW'(1) << (k % 6));
      g = ardy;
      step;
      for (int i = 0; i < N; i++) if (g[i]) begin
        a[i] = a[i] + 1'b1;
        set_addr(i, a[i]);
      end
    end
    avld = '0;
    drain("t2_drain");
    for (int i = 0; i < N; i++) chk($sformatf("t2_rcv%0d", i), DW'(rcv[i] - rb[i]), DW'(3));
    // credit limit with a stalled consumer
    ordy[2] = 1'b0;
    r0 = rcv[2];
    n = 0;
    set_addr(2, 10'h200);
    avld = 6'b000100;
    for (int c = 0; c < 10; c++) begin
      smp;
      g = ardy;
      step;
      if (g[2]) begin
        n++;
        set_addr(2, AW'(10'h200 + n));
      end
    end
    chk("t3_acc", DW'(n), DW'(4));
    smp;
    chk("t3_ardy", DW'(ardy[2]), '0);
    chk("t3_ovld", DW'(ovld[2]), DW'(1));
    chk("t3_head", ofm[2*DW +: DW], word(10'h200));
    step;
    ordy[2] = 1'b1;
    t = 0;
    while (n < 10 && t < 100) begin
      smp;
      g = ardy;
      step;
      t++;
      if (g[2]) begin
        n++;
        set_addr(2, AW'(10'h200 + n));
      end
    end
    avld = '0;
    chk("t3_acc_all", DW'(n), DW'(10));
    drain("t3_drain");
    chk("t3_rcv", DW'(rcv[2] - r0), DW'(10));
    // single-core full rate
    hi = 0;
    ov = 0;
    n = 0;
    set_addr(1, 10'h300);
    avld = 6'b000010;
    for (int c = 0; c < 20; c++) begin
      smp;
      g = ardy;
      if (ardy[1]) hi++;
      if (ovld[1]) ov++;
      step;
      if (g[1]) begin
        n++;
        set_addr(1, AW'(10'h300 + n));
      end
    end
    avld = '0;
    chk("t4_ardy", DW'(hi), DW'(20));
    chk("t4_ovld", DW'(ov), DW'(16));
    drain("t4_drain");
    // flush with three reads in flight
    set_addr(3, 10'h3A0);
    avld = 6'b001000;
    for (int c = 0; c < 3; c++) begin
      smp;
      chk($sformatf("t5_pre%0d", c), DW'(ardy), DW'(6'b001000));
      step;
      set_addr(3, AW'(10'h3A1 + c));
    end
    flush = 1'b1;
    smp;
    chk("t5_ardy_flush", DW'(ardy), '0);
    step;
    flush = 1'b0;
    avld = '0;
    smp;
    chk("t5_rdvld", DW'(rdvld), '0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t5_ovld%0d", c), DW'(ovld), '0);
      step;
      smp;
    end
    r0 = rcv[3];
    step;
    set_addr(3, 10'h333);
    avld = 6'b001000;
    smp;
    chk("t5_ardy", DW'(ardy), DW'(6'b001000));
    step;
    avld = '0;
    step;
    step;
    step;
    smp;
    chk("t5_ovld_new", DW'(ovld), DW'(6'b001000));
    chk("t5_ofm_new", ofm[3*DW +: DW], word(10'h333));
    drain("t5_drain");
    chk("t5_rcv", DW'(rcv[3] - r0), DW'(1));
    // async reset in the middle of a stream
    for (int i = 0; i < N; i++) set_addr(i, AW'(10'h040 + i));
    avld = '1;
    for (int c = 0; c < 5; c++) step;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ardy", DW'(ardy), '0);
    chk("t6_rdvld", DW'(rdvld), '0);
    chk("t6_rdaddr", DW'(rdaddr), '0);
    chk("t6_ovld", DW'(ovld), '0);
    chk("t6_ofm", DW'(|ofm), '0);
    step;
    rst_n = 1'b1;
    smp;
    chk("t6_first", DW'(ardy), DW'(6'b000001));
    step;
    avld = '0;
    drain("t6_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
